// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// Optional packet locking is enabled by defining ARB_PKT_LOCK_EN.
package mux2_arb_pkg;

  // Ownership state: IDLE arbitrates every beat, OWNk locks the grant to k.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester indices as carried on out_src.
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Default widths for the top-level parameters.
  localparam int CNT_W_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational winner selection for two requesters.
// A locked state restricts eligibility to the owning requester; otherwise
// a lone requester wins and a tie is resolved by the priority bit.
module rr_pick2
  import mux2_arb_pkg::*;
(
  input  logic [1:0] in_valid,
  input  logic       prio,
  input  arb_state_t state,
  output logic       win_valid,
  output logic       win_idx
);

  logic [1:0] eligible;

  // Mask out the non-owning requester while a packet holds the grant.
  always_comb begin
    eligible = in_valid;
    case (state)
      IDLE:    eligible = in_valid;
      OWN0:    eligible = in_valid & 2'b01;
      OWN1:    eligible = in_valid & 2'b10;
      default: eligible = in_valid;
    endcase
  end

  // Pick the winner among the eligible requesters.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = SRC0;
    case (eligible)
      2'b01: begin
        win_valid = 1'b1;
        win_idx   = SRC0;
      end
      2'b10: begin
        win_valid = 1'b1;
        win_idx   = SRC1;
      end
      2'b11: begin
        win_valid = 1'b1;
        win_idx   = prio;
      end
      default: begin
        win_valid = 1'b0;
        win_idx   = SRC0;
      end
    endcase
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin share of one registered valid/ready output between two
// requesters, with saturating per-requester grant counters.
// Defining ARB_PKT_LOCK_EN adds in_last and keeps the grant on one requester
// until the last beat of its packet has transferred.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
`ifdef ARB_PKT_LOCK_EN
  input  logic [1:0]        in_last,
`endif
  output logic [1:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t        state_r;
  logic              prio_r;
  logic              win_valid;
  logic              win_idx;
  logic              space;
  logic              xfer;
  logic              both_valid;
  logic              beat_last;
  logic [DATA_W-1:0] sel_data;

  rr_pick2 u_pick (
    .in_valid  (in_valid),
    .prio      (prio_r),
    .state     (state_r),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Handshake qualifiers: slot availability, accept strobe and the 2:1 mux.
  always_comb begin
    space      = !out_valid || out_ready;
    both_valid = &in_valid;
    if (win_valid && space && !rst) begin
      in_ready = win_idx ? 2'b10 : 2'b01;
    end else begin
      in_ready = 2'b00;
    end
    xfer     = |(in_valid & in_ready);
    sel_data = win_idx ? in_data1 : in_data0;
  end

  // Last-beat marker of the winning requester; every beat is last without locking.
  always_comb begin
`ifdef ARB_PKT_LOCK_EN
    beat_last = win_idx ? in_last[1] : in_last[0];
`else
    beat_last = 1'b1;
`endif
  end

  // Output register: load on accept, drain when consumed, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_src   <= SRC0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Round-robin pointer: hand priority to the loser after a contested last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= SRC0;
    end else if (xfer && both_valid && beat_last) begin
      prio_r <= ~win_idx;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Ownership FSM: lock onto a requester for the body of a multi-beat packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
`ifdef ARB_PKT_LOCK_EN
      case (state_r)
        IDLE: begin
          if (xfer && !beat_last) begin
            state_r <= win_idx ? OWN1 : OWN0;
          end else begin
            state_r <= IDLE;
          end
        end
        OWN0, OWN1: begin
          if (xfer && beat_last) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
`else
      state_r <= IDLE;
`endif
    end
  end

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= {CNT_W{1'b0}};
      gnt_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (xfer && (win_idx == SRC0) && (gnt_cnt0 != CNT_MAX)) begin
        gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
      end else begin
        gnt_cnt0 <= gnt_cnt0;
      end
      if (xfer && (win_idx == SRC1) && (gnt_cnt1 != CNT_MAX)) begin
        gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
      end else begin
        gnt_cnt1 <= gnt_cnt1;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios followed by random
// traffic, compared against a rule-level reference model.
// Builds with or without ARB_PKT_LOCK_EN.
module tb_mux2_rr_arbiter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;
`ifdef ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        in_valid = 2'b00;
  logic [DATA_W-1:0] in_data0 = 8'h00;
  logic [DATA_W-1:0] in_data1 = 8'h00;
`ifdef ARB_PKT_LOCK_EN
  logic [1:0]        in_last = 2'b11;
`endif
  logic [1:0]        in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  gnt_cnt0;
  logic [CNT_W-1:0]  gnt_cnt1;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
`ifdef ARB_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (committed after each clock edge).
  logic [8:0] q[$];          // {src, data} beats the output should present
  int         m_prio  = 0;
  int         m_owner = -1;  // -1: nobody owns the grant
  int         m_c0    = 0;
  int         m_c1    = 0;
  // Beat accepted in the current cycle, applied after the coming edge.
  bit         p_xfer  = 1'b0;
  bit         p_rst   = 1'b0;
  int         p_src   = 0;
  logic [7:0] p_data  = 8'h00;
  bit         p_both  = 1'b0;
  bit         p_last  = 1'b1;
  bit         mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner by the rules: owner restricts eligibility, lone requester wins,
  // a tie goes to the priority holder.
  function automatic int pick(input logic [1:0] v);
    logic [1:0] e;
    e = v;
    if (m_owner == 0) e = v & 2'b01;
    if (m_owner == 1) e = v & 2'b10;
    if (e == 2'b11) return m_prio;
    if (e == 2'b01) return 0;
    if (e == 2'b10) return 1;
    return -1;
  endfunction

  // One clock cycle: commit last cycle's effect, check counters, drive new
  // inputs, check in_ready and record the beat that will transfer.
  task automatic cycle(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic ordy, input logic [1:0] lst, input logic r);
    int  w;
    bit  sp;
    logic [1:0] exp_rdy;
    @(posedge clk);
    #1;
    if (p_rst) begin
      q.delete();
      m_prio = 0; m_owner = -1; m_c0 = 0; m_c1 = 0;
    end else if (p_xfer) begin
      q.push_back({p_src[0], p_data});
      if (p_src == 0) m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
      else            m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
      if (p_last) begin
        m_owner = -1;
        if (p_both) m_prio = 1 - p_src;
      end else begin
        m_owner = p_src;
      end
    end
    p_xfer = 1'b0;
    p_rst  = 1'b0;
    if (mon_en) begin
      chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_c0));
      chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_c1));
    end
    #1;
    in_valid  = v;
    in_data0  = d0;
    in_data1  = d1;
    out_ready = ordy;
    rst       = r;
`ifdef ARB_PKT_LOCK_EN
    in_last   = lst;
`endif
    #1;
    w  = pick(v);
    sp = (q.size() == 0) || ordy;
    exp_rdy = 2'b00;
    if (!r && sp && w >= 0) exp_rdy = (w == 1) ? 2'b10 : 2'b01;
    if (mon_en) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      p_rst = 1'b1;
    end else if (exp_rdy != 2'b00) begin
      p_xfer = 1'b1;
      p_src  = w;
      p_data = (w == 1) ? d1 : d0;
      p_both = (v == 2'b11);
      p_last = (w == 1) ? (lst[1] | !LOCK_EN) : (lst[0] | !LOCK_EN);
    end
  endtask

  // Monitor: the output must present exactly the model's queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0][7:0]));
        chk("out_src", 32'(out_src), 32'(q[0][8]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1);
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1);
    mon_en = 1'b1;
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);

    // Lone requester 0
    cycle(2'b01, 8'h11, 8'h55, 1'b1, 2'b11, 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0);

    // Continuous contention: alternating sources
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 6; i++) cycle(2'b11, 8'hA0, 8'hB1, 1'b1, 2'b11, 1'b0);

    // Backpressure for three cycles, then release
    for (int i = 0; i < 3; i++) cycle(2'b11, 8'hA0, 8'hB1, 1'b0, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'b11, 8'hA0, 8'hB1, 1'b1, 2'b11, 1'b0);

    // Saturation of requester 1's counter
    for (int i = 0; i < 20; i++) cycle(2'b10, 8'h00, 8'(i), 1'b1, 2'b11, 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0);

    // Three-beat packet from requester 0 with requester 1 waiting
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1);
    cycle(2'b11, 8'hC0, 8'hD0, 1'b1, 2'b10, 1'b0);
    cycle(2'b11, 8'hC1, 8'hD0, 1'b1, 2'b10, 1'b0);
    cycle(2'b11, 8'hC2, 8'hD0, 1'b1, 2'b11, 1'b0);
    cycle(2'b10, 8'h00, 8'hD0, 1'b1, 2'b11, 1'b0);

    // Reset while the output holds a beat, then contention
    cycle(2'b11, 8'hE0, 8'hE1, 1'b1, 2'b11, 1'b0);
    cycle(2'b11, 8'hE2, 8'hE3, 1'b1, 2'b11, 1'b0);
    cycle(2'b11, 8'hE4, 8'hE5, 1'b0, 2'b11, 1'b1);
    cycle(2'b11, 8'hF0, 8'hF1, 1'b1, 2'b11, 1'b0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(2'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), 2'($urandom),
            ($urandom_range(0, 99) == 0));
    end

    // Drain
    for (int i = 0; i < 4; i++) cycle(2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0);
    chk("drain_empty", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data mux and one registered output channel between two requesters (port 0, port 1) using round-robin arbitration.
- Each requester uses a valid/ready handshake. The output is a single registered valid/ready stream tagged with the source index.
- Sits in front of any single-consumer resource that two producers must share. Keeps saturating per-requester grant counters for debug.

Parameters:
- DATA_W, 8, payload width per requester.
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  2  bit k: requester k has a beat.
- in_data0  input  DATA_W  requester 0 payload.
- in_data1  input  DATA_W  requester 1 payload.
- in_ready  output  2  bit k: requester k's beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered payload.
- out_src  output  1  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the output beat.
- gnt_cnt0  output  CNT_W  beats accepted from requester 0, saturating.
- gnt_cnt1  output  CNT_W  beats accepted from requester 1, saturating.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_src=0, prio=0 (requester 0 favoured first), state=IDLE, gnt_cnt0=gnt_cnt1=0.
- Slot free: space = !out_valid || out_ready (combinational).
- Winner selection, combinational:
  - Only one in_valid bit set: that requester wins.
  - Both set: requester prio wins.
  - Neither set: no winner.
- in_ready[k] = winner==k && space. in_ready depends on in_valid; in_valid must never depend on in_ready.
- Input transfer: in_valid[k] && in_ready[k]. At most one transfer per cycle.
- On transfer from k:
  - out_data <= in_data_k (via the 2:1 select), out_src <= k, out_valid <= 1.
  - gnt_cntk += 1, saturating at all-ones.
  - prio <= ~k only when both requesters were valid that cycle; otherwise prio unchanged.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their values.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure: out_valid=1 && out_ready=0 → both in_ready=0 and the output register holds.
- Simultaneous output drain and input transfer in the same cycle: the new beat replaces the old, out_valid stays 1, no bubble.
- FSM states:
  - IDLE: no ownership.
  - OWN0 / OWN1: grant locked to one requester.
  - Without the optional feature the FSM stays in IDLE permanently.
- Reset asserted mid-transfer: the beat is dropped, all state returns to reset values the next cycle, in_ready=0 during reset.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined:
  - Adds input in_last (2 bits) marking the final beat of a packet.
  - A transfer from k with in_last[k]=0 moves the FSM IDLE→OWNk.
  - In OWNk, winner is forced to k regardless of prio, and the other requester's in_ready stays 0.
  - A transfer with in_last[k]=1 returns the FSM to IDLE and applies the prio update; prio is otherwise frozen while in OWNk.
  - Single-beat packets (in_last=1 on the first beat) never leave IDLE.
- Undefined: no in_last port; every beat is treated as last; arbitration happens every beat.

Decomposition:
- Shared package mux2_arb_pkg:
  - state typedef {IDLE, OWN0, OWN1}.
  - Constants SRC0=1'b0, SRC1=1'b1.
  - CNT_W default.
- One sub-module, rr_pick2: combinational winner/valid computation from in_valid, prio and lock state. The top level keeps the registers, FSM and counters.

Test Plan:
- Reset, then only requester 0 valid, data 0x11, out_ready=1 → in_ready=2'b01; next cycle out_valid=1, out_data=0x11, out_src=0; gnt_cnt0=1.
- Both requesters valid continuously (data0=0xA0, data1=0xB1), out_ready=1 → output sequence src 0,1,0,1 with data alternating 0xA0/0xB1, one beat per cycle.
- out_valid=1 and out_ready=0 for 3 cycles with both inputs valid → in_ready=0, out_data stable for 3 cycles; on release the output continues in round-robin order with no loss.
- CNT_W=4, 20 beats from requester 1 → gnt_cnt1=15 and holds.
- ARB_PKT_LOCK_EN: requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid throughout → three src-0 beats, then requester 1 is granted.
- rst asserted for 1 cycle while out_valid=1 → next cycle out_valid=0, counters=0, and the first grant after reset goes to requester 0 under contention.
